// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state type for the sequential MIPS ALU.
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Divider datapath exists only when SEQ_ALU_DIV_EN is defined.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic [WIDTH:0]   w_msum;

  // Multiply: conditionally add multiplicand into the upper half, then shift right.
  assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);

`ifdef SEQ_ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ok;
  logic             w_unused_div;

  assign w_shift      = {r_acc, r_q[WIDTH-1]};
  assign w_diff       = {1'b0, w_shift} - {2'b00, r_b};
  assign w_ok         = ~w_diff[WIDTH+1];
  assign w_unused_div = w_diff[WIDTH];

  // Divide by zero always "fits": quotient fills with ones, remainder becomes the dividend.
  always_comb begin
    if (r_div) begin
      o_hi_nxt = w_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_lo_nxt = {r_q[WIDTH-2:0], w_ok};
    end else begin
      o_hi_nxt = w_msum[WIDTH:1];
      o_lo_nxt = {w_msum[0], r_q[WIDTH-1:1]};
    end
  end
`else
  assign o_hi_nxt = w_msum[WIDTH:1];
  assign o_lo_nxt = {w_msum[0], r_q[WIDTH-1:1]};
`endif

  assign o_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_load) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
`ifdef SEQ_ALU_DIV_EN
      r_div <= i_div;
`endif
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= o_hi_nxt;
      r_q   <= o_lo_nxt;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Clocked MIPS execute-stage ALU: single-cycle logic/arith ops plus iterative
// MULTU/DIVU writing HI. DIVU is built only with SEQ_ALU_DIV_EN defined.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);
  state_t           r_state;
  logic             w_iter, w_load, w_last;
  logic [WIDTH-1:0] w_alu, w_lo_nxt, w_hi_nxt;

`ifdef SEQ_ALU_DIV_EN
  assign w_iter = (Control == ALU_MULTU) || (Control == ALU_DIVU);
`else
  assign w_iter = (Control == ALU_MULTU);
`endif
  assign w_load = (r_state == IDLE) && start && w_iter;

  always_comb begin
    w_alu = '0;
    case (Control)
      ALU_AND: w_alu = in1 & in2;
      ALU_OR:  w_alu = in1 | in2;
      ALU_ADD: w_alu = in1 + in2;
      ALU_SUB: w_alu = in1 - in2;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: w_alu = '0;
    endcase
  end

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
`ifdef SEQ_ALU_DIV_EN
    .i_div    (Control == ALU_DIVU),
`endif
    .i_run    (r_state == RUN),
    .i_a      (in1),
    .i_b      (in2),
    .o_last   (w_last),
    .o_lo_nxt (w_lo_nxt),
    .o_hi_nxt (w_hi_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Result  <= '0;
      hi      <= '0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (w_iter) begin
            r_state <= RUN;
            busy    <= 1'b1;
          end else begin
            Result <= w_alu;
            zero   <= (w_alu == '0);
            done   <= 1'b1;
          end
        end
        RUN: if (w_last) begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          Result  <= w_lo_nxt;
          hi      <= w_hi_nxt;
          zero    <= (w_lo_nxt == '0);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32 and WIDTH=8 instances) against an
// arithmetic reference model; expectations follow SEQ_ALU_DIV_EN when defined.
module tb_seq_alu;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, start8;
  logic [3:0]  ctl, ctl8;
  logic [31:0] a, b, res, hi;
  logic [7:0]  a8, b8, res8, hi8;
  logic        busy, done, zero, busy8, done8, zero8;

  int          vecs = 0;
  int          fails = 0;
  logic [31:0] exp_hi;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Control(ctl), .in1(a), .in2(b),
    .busy(busy), .done(done), .Result(res), .hi(hi), .zero(zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .Control(ctl8), .in1(a8), .in2(b8),
    .busy(busy8), .done(done8), .Result(res8), .hi(hi8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit instance and check completion against the model.
  task automatic run32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [63:0] p;
    bit          it;
    int          n;
    it = 1'b0;
    er = '0;
    case (c)
      4'b0000: er = x & y;
      4'b0001: er = x | y;
      4'b0010: er = x + y;
      4'b0110: er = x - y;
      4'b0111: er = (x < y) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = 64'(x) * 64'(y);
        er = p[31:0];
        exp_hi = p[63:32];
        it = 1'b1;
      end
      4'b1001: if (DIV_EN) begin
        it = 1'b1;
        if (y == 0) begin er = '1; exp_hi = x; end
        else begin er = x / y; exp_hi = x % y; end
      end
      default: er = '0;
    endcase
    @(negedge clk);
    start = 1'b1; ctl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; ctl = 4'($urandom); a = $urandom; b = $urandom;
    n = 0;
    if (it) begin
      chk("busy_after_accept", busy, 1);
      chk("no_early_done", done, 0);
      while (!done && n < 100) begin
        start = (n < 5);  // requests while busy must be dropped
        ctl   = 4'($urandom);
        @(posedge clk); #1;
        n++;
      end
      start = 1'b0;
      chk("iter_latency", n, 32);
    end
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("Result", res, er);
    chk("hi", hi, exp_hi);
    chk("zero", zero, (er == 0));
  endtask

  task automatic run8_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    int          n;
    p = 16'(x) * 16'(y);
    @(negedge clk);
    start8 = 1'b1; ctl8 = 4'b1000; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_latency", n, 8);
    chk("w8_product", {hi8, res8}, p);
    chk("w8_zero", zero8, (p[7:0] == 0));
  endtask

  initial begin
    logic [3:0] codes [8];
    int         dpulses;
    reset = 1'b1; start = 1'b0; ctl = '0; a = '0; b = '0;
    start8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;
    exp_hi = '0;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0011};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_Result", res, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w8", {busy8, done8, zero8, res8, hi8}, 0);
    @(negedge clk);
    reset = 1'b0;

    run32(4'b0010, 32'd5, 32'd7);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("busy_single", busy, 0);

    run32(4'b0110, 32'd3, 32'd3);
    run32(4'b0111, 32'd2, 32'd9);
    run32(4'b1000, 32'hFFFF_FFFF, 32'd2);
    run32(4'b0111, 32'd9, 32'd2);
    run32(4'b1001, 32'd100, 32'd7);
    run32(4'b1001, 32'd55, 32'd0);
    run32(4'b0010, 32'hFFFF_FFFF, 32'd1);
    run32(4'b0110, 32'd0, 32'd1);
    run32(4'b1100, 32'd1, 32'd2);

    // Abort a multiply ten cycles in with reset.
    @(negedge clk);
    start = 1'b1; ctl = 4'b1000; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {busy, done, zero, res, hi}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    dpulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) dpulses++;
    end
    chk("abort_no_done", dpulses, 0);
    run32(4'b0010, 32'd1, 32'd1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run32(codes[$urandom_range(0, 7)], x, y);
    end

    run8_mul(8'd200, 8'd3);
    for (int i = 0; i < 4; i++) run8_mul(8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked ALU for the MIPS datapath. It extends the combinational ALU operation set (AND/OR/ADD/SUB/SLT) with iterative unsigned multiply and divide that write a HI register. A start/busy/done handshake lets the controller stall on multi-cycle operations. It sits in the execute stage and drives the ALU result, the zero flag and the HI value used by mfhi.

## Interface
- WIDTH, 32, operand/result width in bits (≥4).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- Control  in  4  operation code, sampled with start.
- in1  in  WIDTH  operand A, sampled with start.
- in2  in  WIDTH  operand B, sampled with start.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result/hi/zero updated this cycle.
- Result  out  WIDTH  registered result (low product / quotient for mul/div).
- hi  out  WIDTH  registered HI (high product / remainder).
- zero  out  1  registered, equals (Result==0).

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH, no overflow flag)
  - 0110 SUB (mod 2^WIDTH)
  - 0111 SLT: unsigned in1<in2 gives 1, else 0
  - 1000 MULTU
  - 1001 DIVU
  - any other code: Result=0.
- Single-cycle ops (all but 1000/1001) update Result and zero; hi holds its value.
- MULTU: shift-add over WIDTH iterations. Full 2·WIDTH product: {hi, Result}.
- DIVU: restoring division over WIDTH iterations. Result=quotient, hi=remainder.
  - Divide by zero still takes WIDTH cycles and yields Result=all ones, hi=in1.
- FSM states:
  - IDLE: start with 1000/1001 goes to RUN; start with any other code stays in IDLE and completes in one cycle.
  - RUN: iteration counter counts 0..WIDTH-1. At the last iteration, go to IDLE and pulse done.
- start while busy=1 is ignored; no queuing.
- Operands are latched at acceptance, so in1/in2/Control may change during RUN.
- Outputs hold between done pulses.

## Timing
- Reset value of every output and internal register is 0: Result, hi, zero, busy, done and counter. The state is IDLE.
  - zero resets to 0 even though Result=0, because zero only reflects completed ops.
- Single-cycle op accepted at edge E0: done=1 and outputs valid after E0; done returns to 0 after E1. Latency 1.
- Mul/div accepted at edge E0:
  - busy=1 after E0 through E(WIDTH-1).
  - At E(WIDTH), busy drops and done=1 for one cycle with final Result/hi/zero.
  - Latency WIDTH cycles.
- Back-to-back: start may be asserted in the same cycle that done=1. It is accepted because busy=0.
- Reset asserted mid-RUN aborts the operation:
  - All outputs clear at that edge.
  - No done pulse is issued.
  - Partial results are discarded.
- zero is computed from the final Result value and registered in the same edge as Result.

## Configuration
- SEQ_ALU_DIV_EN defined: DIVU (1001) is implemented as above.
- SEQ_ALU_DIV_EN undefined:
  - Divider logic is compiled out.
  - Code 1001 behaves as an undefined code: Result=0, zero=1, hi unchanged, done after 1 cycle, busy never asserted.
  - MULTU is unaffected.

## Structure
- Shared package alu_pkg holds:
  - Operation code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MULTU, ALU_DIVU.
  - FSM state typedef (IDLE, RUN).
- Sub-module mul_div_iter holds the iterative datapath:
  - Shift registers and a counter of width $clog2(WIDTH).
  - The add/subtract step.
- seq_alu top holds the FSM, the single-cycle ops and the output registers.

## Test plan
- ADD in1=5, in2=7 -> after one edge: Result=12, zero=0, done pulse width 1, busy stays 0.
- SUB 3−3, then SLT 2<9 back-to-back -> Result=0 with zero=1, then Result=1 with zero=0. hi stays 0.
- MULTU 0xFFFFFFFF×2 (WIDTH=32) -> busy for 32 cycles, done exactly 32 edges after acceptance, hi=1, Result=0xFFFFFFFE. A start during busy is ignored.
- DIVU 100/7 -> Result=14, hi=2 after 32 cycles. DIVU 55/0 -> Result=0xFFFFFFFF, hi=55. With SEQ_ALU_DIV_EN undefined: Result=0, 1-cycle done.
- Reset asserted at cycle 10 of a MULTU -> all outputs 0 on the next edge, no done. The next ADD 1+1 gives 2 with latency 1.
- WIDTH=8 instance, MULTU 200×3 -> {hi, Result}=0x0258 after 8 cycles.
